// File: rtl/wb_xbar_rr.sv
// Wishbone-style N_MST x N_SLV crossbar: base/mask address decode, per-slave
// round-robin arbitration, decode-error response and per-slave ack timeout.

module wb_xbar_slv #(
  parameter int N_MST   = 2,
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15,
  parameter int TW      = 4,
  parameter int MW      = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [N_MST-1:0]    req_i,
  input  logic [N_MST-1:0]    m_we_i,
  input  logic [N_MST*AW-1:0] m_addr_i,
  input  logic [N_MST*DW-1:0] m_data_i,
  input  logic                s_ack_i,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [AW-1:0]       s_addr_o,
  output logic [DW-1:0]       s_data_o,
  output logic [MW-1:0]       owner_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                tmo_o
);
  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q;
  logic [MW-1:0]   last_q, owner_q, gnt_idx;
  logic [TW-1:0]   cnt_q;
  logic            stb_q, we_q, gnt_vld;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;

  // Scan masters starting just after the last one served.
  always_comb begin : arb
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= N_MST; k++) begin
      j = int'(last_q) + k;
      if (j >= N_MST) j = j - N_MST;
      if (!gnt_vld && req_i[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = MW'(j);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      owner_q <= '0;
      last_q  <= MW'(N_MST - 1);
    end else begin
      case (state_q)
        IDLE: if (gnt_vld) begin
          state_q <= BUSY;
          stb_q   <= 1'b1;
          we_q    <= m_we_i[gnt_idx];
          addr_q  <= m_addr_i[int'(gnt_idx)*AW +: AW];
          data_q  <= m_data_i[int'(gnt_idx)*DW +: DW];
          owner_q <= gnt_idx;
          cnt_q   <= '0;
        end
        BUSY: if (s_ack_i) begin
          state_q <= IDLE;
          stb_q   <= 1'b0;
          last_q  <= owner_q;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          state_q <= IDLE;
          stb_q   <= 1'b0;
        end else begin
          cnt_q   <= cnt_q + 1'b1;
        end
      endcase
    end
  end

  assign s_stb_o  = stb_q;
  assign s_we_o   = we_q;
  assign s_addr_o = addr_q;
  assign s_data_o = data_q;
  assign owner_o  = owner_q;
  assign busy_o   = (state_q == BUSY);
  assign done_o   = busy_o & s_ack_i;
  assign tmo_o    = busy_o & ~s_ack_i & (cnt_q == TW'(TIMEOUT - 1));
endmodule

module wb_xbar_rr #(
  parameter int                  N_MST    = 2,
  parameter int                  N_SLV    = 4,
  parameter int                  AW       = 16,
  parameter int                  DW       = 32,
  parameter logic [N_SLV*AW-1:0] SLV_BASE = {16'hC000, 16'h8000, 16'h4000, 16'h0000},
  parameter logic [N_SLV*AW-1:0] SLV_MASK = {16'hF000, 16'hC000, 16'hC000, 16'hC000},
  parameter int                  TIMEOUT  = 15,
  parameter int                  TW       = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [N_MST-1:0]    m_stb_i,
  input  logic [N_MST-1:0]    m_we_i,
  input  logic [N_MST*AW-1:0] m_addr_i,
  input  logic [N_MST*DW-1:0] m_data_i,
  output logic [N_MST-1:0]    m_ack_o,
  output logic [N_MST-1:0]    m_err_o,
  output logic [N_MST-1:0]    m_stall_o,
  output logic [N_MST*DW-1:0] m_data_o,
  output logic [N_SLV-1:0]    s_stb_o,
  output logic [N_SLV-1:0]    s_we_o,
  output logic [N_SLV*AW-1:0] s_addr_o,
  output logic [N_SLV*DW-1:0] s_data_o,
  input  logic [N_SLV-1:0]    s_ack_i,
  input  logic [N_SLV*DW-1:0] s_data_i
);
  localparam int MW = (N_MST > 1) ? $clog2(N_MST) : 1;

  logic [N_MST-1:0][N_SLV-1:0] hit;
  logic [N_SLV-1:0][N_MST-1:0] req;
  logic [N_SLV-1:0][MW-1:0]    owner;
  logic [N_SLV-1:0]            busy, done, tmo;
  logic [N_MST-1:0]            any_hit, owned, elig;
  logic [N_MST-1:0]            ack_q, ack_d, err_q, err_d;
  logic [N_MST-1:0][DW-1:0]    rdata_q, rdata_d;

  // Lowest-numbered matching slave wins on overlapping windows.
  always_comb begin
    hit     = '0;
    any_hit = '0;
    for (int m = 0; m < N_MST; m++)
      for (int s = 0; s < N_SLV; s++)
        if (!any_hit[m] &&
            ((m_addr_i[m*AW +: AW] & SLV_MASK[s*AW +: AW]) == SLV_BASE[s*AW +: AW])) begin
          hit[m][s]  = 1'b1;
          any_hit[m] = 1'b1;
        end
  end

  always_comb begin
    owned = '0;
    for (int m = 0; m < N_MST; m++)
      for (int s = 0; s < N_SLV; s++)
        if (busy[s] && owner[s] == MW'(m)) owned[m] = 1'b1;
  end

  assign elig      = m_stb_i & ~ack_q & ~err_q & ~owned;
  assign m_stall_o = m_stb_i & ~owned & ~ack_q & ~err_q;

  always_comb begin
    req = '0;
    for (int s = 0; s < N_SLV; s++)
      for (int m = 0; m < N_MST; m++)
        req[s][m] = elig[m] & hit[m][s];
  end

  // Completion routing: ack/err back to the owning master, read data latched.
  always_comb begin
    ack_d   = '0;
    err_d   = elig & ~any_hit;
    rdata_d = rdata_q;
    for (int m = 0; m < N_MST; m++)
      for (int s = 0; s < N_SLV; s++)
        if (owner[s] == MW'(m)) begin
          if (done[s]) begin
            ack_d[m]   = 1'b1;
            rdata_d[m] = s_data_i[s*DW +: DW];
          end
          if (tmo[s]) err_d[m] = 1'b1;
        end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign m_ack_o  = ack_q;
  assign m_err_o  = err_q;
  assign m_data_o = rdata_q;

  for (genvar s = 0; s < N_SLV; s++) begin : g_slv
    wb_xbar_slv #(
      .N_MST(N_MST), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .TW(TW), .MW(MW)
    ) u_slv (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .req_i   (req[s]),
      .m_we_i  (m_we_i),
      .m_addr_i(m_addr_i),
      .m_data_i(m_data_i),
      .s_ack_i (s_ack_i[s]),
      .s_stb_o (s_stb_o[s]),
      .s_we_o  (s_we_o[s]),
      .s_addr_o(s_addr_o[s*AW +: AW]),
      .s_data_o(s_data_o[s*DW +: DW]),
      .owner_o (owner[s]),
      .busy_o  (busy[s]),
      .done_o  (done[s]),
      .tmo_o   (tmo[s])
    );
  end
endmodule
